// File: rtl/ram_arbiter_if.sv
// Two-port request/ack bus plus the shared RAM port seen by ram_arbiter.
// The slave modport is the arbiter's view; master is the requesters' and RAM's view.
interface ram_arbiter_if;
    logic        prio_mode;

    logic        p0_req;
    logic        p0_we;
    logic [7:0]  p0_addr;
    logic [15:0] p0_wdata;
    logic        p0_ack;
    logic [15:0] p0_rdata;
    logic        p0_rvalid;

    logic        p1_req;
    logic        p1_we;
    logic [7:0]  p1_addr;
    logic [15:0] p1_wdata;
    logic        p1_ack;
    logic [15:0] p1_rdata;
    logic        p1_rvalid;

    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        busy;

    modport slave (
        input  prio_mode,
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ack, p0_rdata, p0_rvalid,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ack, p1_rdata, p1_rvalid,
        output ram_we, ram_addr, ram_wdata,
        input  ram_rdata,
        output busy
    );

    modport master (
        output prio_mode,
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ack, p0_rdata, p0_rvalid,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ack, p1_rdata, p1_rvalid,
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata,
        input  busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a 256x16 asynchronous-read RAM: one access per
// ACCESS cycle, back-to-back grants chain without an IDLE bubble.
module ram_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    ram_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        we_q, we_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [15:0] rdata0_q, rdata0_d;
    logic [15:0] rdata1_q, rdata1_d;
    logic        busy_q;

    logic        grant;
    logic        grant_port;
    logic        other_req;

    // The owner's own req is stale in ACCESS; only the other port may chain in.
    assign other_req = owner_q ? bus.p0_req : bus.p1_req;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ack_d      = 2'b00;
        rvalid_d   = 2'b00;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        grant      = 1'b0;
        grant_port = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.p0_req || bus.p1_req) begin
                    grant = 1'b1;
                    if (bus.p0_req && bus.p1_req)
                        grant_port = bus.prio_mode ? 1'b0 : ~last_q;
                    else
                        grant_port = bus.p1_req;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rvalid_d[owner_q] = 1'b1;
                    if (owner_q)
                        rdata1_d = bus.ram_rdata;
                    else
                        rdata0_d = bus.ram_rdata;
                end
                if (other_req) begin
                    grant      = 1'b1;
                    grant_port = ~owner_q;
                end
            end
            default: ;
        endcase

        if (grant) begin
            state_d            = ACCESS;
            owner_d            = grant_port;
            last_d             = grant_port;
            we_d               = grant_port ? bus.p1_we    : bus.p0_we;
            addr_d             = grant_port ? bus.p1_addr  : bus.p0_addr;
            wdata_d            = grant_port ? bus.p1_wdata : bus.p0_wdata;
            ack_d[grant_port]  = 1'b1;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack_q    <= 2'b00;
            rvalid_q <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= grant;
        end
    end

    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.p0_ack    = ack_q[0];
    assign bus.p1_ack    = ack_q[1];
    assign bus.p0_rvalid = rvalid_q[0];
    assign bus.p1_rvalid = rvalid_q[1];
    assign bus.p0_rdata  = rdata0_q;
    assign bus.p1_rdata  = rdata1_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: cycle table with hand-computed outputs,
// then reset-edge write commit and continuous round-robin contention.
module tb_ram_arbiter;

    logic clk;
    logic rst_n;
    ram_arbiter_if bus ();

    ram_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 256x16 RAM: asynchronous read, write on the rising edge.
    logic [15:0] mem [256];
    assign bus.ram_rdata = mem[bus.ram_addr];
    always @(posedge clk) if (bus.ram_we === 1'b1) mem[bus.ram_addr] <= bus.ram_wdata;

    typedef struct {
        logic        rst, prio;
        logic        r0, w0; logic [7:0] a0; logic [15:0] d0;
        logic        r1, w1; logic [7:0] a1; logic [15:0] d1;
        logic        ack0, ack1, rv0, rv1, busy, rwe;
        logic [7:0]  raddr;
        logic [15:0] rd0, rd1;
    } vec_t;

    localparam int NV = 35;
    vec_t tbl [NV];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic prio,
                         input logic r0, input logic w0, input logic [7:0] a0, input logic [15:0] d0,
                         input logic r1, input logic w1, input logic [7:0] a1, input logic [15:0] d1);
        rst_n         = rst;
        bus.prio_mode = prio;
        bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
        bus.p1_req = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h80] = 16'h000A;
        mem[8'h40] = 16'h1111;

        //          rst  prio r0   w0   a0     d0        r1   w1   a1     d1        ack0 ack1 rv0  rv1  busy rwe  raddr  rd0       rd1
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,16'h0000,16'h0000};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,16'h0000,16'h0000};
        // single read of 0x80
        tbl[2]  = '{1'b1,1'b0,1'b1,1'b0,8'h80,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,8'h80,16'h0000,16'h0000};
        tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,8'h80,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h80,16'h000A,16'h0000};
        tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h80,16'h000A,16'h0000};
        // single write by p1, then p0 reads it back
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b1,1'b1,8'hFF,16'h1234,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,8'hFF,16'h000A,16'h0000};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'hFF,16'h000A,16'h0000};
        tbl[7]  = '{1'b1,1'b0,1'b1,1'b0,8'hFF,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,8'hFF,16'h000A,16'h0000};
        tbl[8]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'hFF,16'h1234,16'h0000};
        tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'hFF,16'h1234,16'h0000};
        // fixed-priority tie: port 0 first, port 1 chained
        tbl[10] = '{1'b1,1'b1,1'b1,1'b0,8'h80,16'h0000,1'b1,1'b0,8'hFF,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,8'h80,16'h1234,16'h0000};
        tbl[11] = '{1'b1,1'b1,1'b0,1'b0,8'h00,16'h0000,1'b1,1'b0,8'hFF,16'h0000,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,8'hFF,16'h000A,16'h0000};
        tbl[12] = '{1'b1,1'b1,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'hFF,16'h000A,16'h1234};
        tbl[13] = '{1'b1,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'hFF,16'h000A,16'h1234};
        // round-robin tie after a port-1 grant goes to port 0
        tbl[14] = '{1'b1,1'b0,1'b1,1'b0,8'h80,16'h0000,1'b1,1'b0,8'hFF,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,8'h80,16'h000A,16'h1234};
        tbl[15] = '{1'b1,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b1,1'b0,8'hFF,16'h0000,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,8'hFF,16'h000A,16'h1234};
        tbl[16] = '{1'b1,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'hFF,16'h000A,16'h1234};
        // stale req: p0 keeps req high through its ack cycle
        tbl[17] = '{1'b1,1'b0,1'b1,1'b0,8'h80,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,8'h80,16'h000A,16'h1234};
        tbl[18] = '{1'b1,1'b0,1'b1,1'b0,8'h80,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h80,16'h000A,16'h1234};
        tbl[19] = '{1'b1,1'b0,1'b1,1'b0,8'h80,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,8'h80,16'h000A,16'h1234};
        tbl[20] = '{1'b1,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h80,16'h000A,16'h1234};
        // round-robin tie after a port-0 grant goes to port 1
        tbl[21] = '{1'b1,1'b0,1'b1,1'b0,8'h80,16'h0000,1'b1,1'b0,8'hFF,16'h0000,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'hFF,16'h000A,16'h1234};
        tbl[22] = '{1'b1,1'b0,1'b1,1'b0,8'h80,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,8'h80,16'h000A,16'h1234};
        tbl[23] = '{1'b1,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h80,16'h000A,16'h1234};
        // same address: p1 read granted before p0 write
        tbl[24] = '{1'b1,1'b0,1'b1,1'b1,8'h40,16'hBEEF,1'b1,1'b0,8'h40,16'h0000,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h40,16'h000A,16'h1234};
        tbl[25] = '{1'b1,1'b0,1'b1,1'b1,8'h40,16'hBEEF,1'b0,1'b0,8'h00,16'h0000,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,8'h40,16'h000A,16'h1111};
        tbl[26] = '{1'b1,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h40,16'h000A,16'h1111};
        tbl[27] = '{1'b1,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b1,1'b0,8'h40,16'h0000,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h40,16'h000A,16'h1111};
        tbl[28] = '{1'b1,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h40,16'h000A,16'hBEEF};
        // reset during a p0 read ACCESS
        tbl[29] = '{1'b1,1'b0,1'b1,1'b0,8'h80,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,8'h80,16'h000A,16'hBEEF};
        tbl[30] = '{1'b0,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,16'h0000,16'h0000};
        tbl[31] = '{1'b1,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,16'h0000,16'h0000};
        tbl[32] = '{1'b1,1'b0,1'b1,1'b0,8'h80,16'h0000,1'b1,1'b0,8'hFF,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,8'h80,16'h0000,16'h0000};
        tbl[33] = '{1'b1,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b1,1'b0,8'hFF,16'h0000,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,8'hFF,16'h000A,16'h0000};
        tbl[34] = '{1'b1,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'hFF,16'h000A,16'h1234};

        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].prio, tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                  tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            step();
            check($sformatf("row%0d p0_ack", i),    16'(bus.p0_ack),    16'(tbl[i].ack0));
            check($sformatf("row%0d p1_ack", i),    16'(bus.p1_ack),    16'(tbl[i].ack1));
            check($sformatf("row%0d p0_rvalid", i), 16'(bus.p0_rvalid), 16'(tbl[i].rv0));
            check($sformatf("row%0d p1_rvalid", i), 16'(bus.p1_rvalid), 16'(tbl[i].rv1));
            check($sformatf("row%0d busy", i),      16'(bus.busy),      16'(tbl[i].busy));
            check($sformatf("row%0d ram_we", i),    16'(bus.ram_we),    16'(tbl[i].rwe));
            check($sformatf("row%0d ram_addr", i),  16'(bus.ram_addr),  16'(tbl[i].raddr));
            check($sformatf("row%0d p0_rdata", i),  bus.p0_rdata,       tbl[i].rd0);
            check($sformatf("row%0d p1_rdata", i),  bus.p1_rdata,       tbl[i].rd1);
        end
        check("mem40 after write", mem[8'h40], 16'hBEEF);

        // A write whose ACCESS cycle meets the reset edge still lands in RAM.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h22, 16'h5A5A);
        step();
        check("rstwr ack1", 16'(bus.p1_ack), 16'h1);
        check("rstwr ram_we", 16'(bus.ram_we), 16'h1);
        check("rstwr ram_wdata", bus.ram_wdata, 16'h5A5A);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        step();
        check("rstwr busy", 16'(bus.busy), 16'h0);
        check("rstwr ram_we off", 16'(bus.ram_we), 16'h0);
        check("rstwr mem22", mem[8'h22], 16'h5A5A);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h22, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        step();
        check("rstwr readback ack0", 16'(bus.p0_ack), 16'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        step();
        check("rstwr readback rvalid", 16'(bus.p0_rvalid), 16'h1);
        check("rstwr readback data", bus.p0_rdata, 16'h5A5A);

        // Continuous contention from fresh reset: owners alternate 0,1,0,1,...
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h80, 16'h0000, 1'b1, 1'b0, 8'hFF, 16'h0000);
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("rr%0d p0_ack", k), 16'(bus.p0_ack), 16'((k % 2) == 0));
            check($sformatf("rr%0d p1_ack", k), 16'(bus.p1_ack), 16'((k % 2) == 1));
            check($sformatf("rr%0d busy", k),   16'(bus.busy),   16'h1);
            check($sformatf("rr%0d ram_addr", k), 16'(bus.ram_addr), ((k % 2) == 0) ? 16'h0080 : 16'h00FF);
            if (k > 0)
                check($sformatf("rr%0d rdata", k), ((k % 2) == 0) ? bus.p1_rdata : bus.p0_rdata,
                      ((k % 2) == 0) ? 16'h1234 : 16'h000A);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        step();
        check("rr end busy", 16'(bus.busy), 16'h0);
        step();
        check("rr end idle ack", 16'({bus.p0_ack, bus.p1_ack}), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Mutual exclusion of acks and no RAM write outside ACCESS, every cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && total > 0) begin
            if (bus.p0_ack === 1'b1 && bus.p1_ack === 1'b1) begin
                bad++;
                $display("FAIL ack_overlap: got p0_ack=1 p1_ack=1 want at most one");
            end
            if (bus.ram_we === 1'b1 && bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL we_outside_access: got ram_we=1 busy=%b want busy=1", bus.busy);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
